// File: rtl/instruction_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues pipelined memory requests and queues responses for decode.
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue is presented to decode in the same cycle.
module instruction_fetch_queue #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     QUEUE_DEPTH  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    output logic            o_MemReqValid,
    input  logic            i_MemReqReady,
    output logic [XLEN-1:0] o_MemReqAddress,
    input  logic            i_MemRespValid,
    input  logic [31:0]     i_MemRespData,
    input  logic            i_Redirect,
    input  logic [XLEN-1:0] i_RedirectTarget,
    output logic            o_InstrValid,
    input  logic            i_InstrReady,
    output logic [31:0]     o_InstrWord,
    output logic [XLEN-1:0] o_InstrAddress
);
    localparam int unsigned IDXW = $clog2(QUEUE_DEPTH);
    localparam int unsigned PTRW = IDXW + 1;
    localparam int unsigned DISW = $clog2(QUEUE_DEPTH + 1);

    logic [XLEN-1:0]        r_FetchPc;
    logic [PTRW-1:0]        r_Head;
    logic [PTRW-1:0]        r_Tail;
    logic [PTRW-1:0]        r_Fill;
    logic [QUEUE_DEPTH-1:0] r_DataValid;
    logic [DISW-1:0]        r_Discard;
    logic [XLEN-1:0]        r_Addr [QUEUE_DEPTH];
    logic [31:0]            r_Data [QUEUE_DEPTH];

    logic [IDXW-1:0] w_HeadIdx;
    logic [IDXW-1:0] w_TailIdx;
    logic [IDXW-1:0] w_FillIdx;
    logic [PTRW-1:0] w_Reserved;
    logic [PTRW-1:0] w_InFlight;
    logic            w_ReqValid;
    logic            w_ReqFire;
    logic            w_Discarding;
    logic            w_RespKeep;
    logic            w_QueueValid;
    logic            w_Bypass;
    logic            w_InstrValid;
    logic            w_Pop;
    logic            w_Write;
    logic [DISW:0]   w_DiscardSum;
    logic [XLEN-1:0] w_RedirectPc;

    assign w_HeadIdx    = r_Head[IDXW-1:0];
    assign w_TailIdx    = r_Tail[IDXW-1:0];
    assign w_FillIdx    = r_Fill[IDXW-1:0];
    assign w_Reserved   = r_Tail - r_Head;
    assign w_InFlight   = r_Tail - r_Fill;
    assign w_ReqValid   = !i_Reset && !i_Redirect && (w_Reserved < PTRW'(QUEUE_DEPTH));
    assign w_ReqFire    = w_ReqValid && i_MemReqReady;
    assign w_Discarding = (r_Discard != '0);
    assign w_RespKeep   = i_MemRespValid && !w_Discarding;
    assign w_QueueValid = r_DataValid[w_HeadIdx] && (r_Head != r_Tail);
    assign w_RedirectPc = i_RedirectTarget & ~XLEN'(3);

`ifdef FETCH_BYPASS_EN
    assign w_Bypass = w_RespKeep && (r_Head == r_Fill);
`else
    assign w_Bypass = 1'b0;
`endif

    assign w_InstrValid = !i_Reset && (w_QueueValid || w_Bypass);
    assign w_Pop        = w_InstrValid && i_InstrReady;
    // A bypassed response that decode takes this cycle never occupies its slot.
    assign w_Write      = w_RespKeep && !(w_Bypass && i_InstrReady);

    // Every response still owed to us becomes stale on redirect; one arriving now is already accounted for.
    assign w_DiscardSum = (DISW+1)'(r_Discard) + (DISW+1)'(w_InFlight) - (DISW+1)'(i_MemRespValid);

    assign o_MemReqValid   = w_ReqValid;
    assign o_MemReqAddress = r_FetchPc;
    assign o_InstrValid    = w_InstrValid;

    always_comb begin
        o_InstrWord    = '0;
        o_InstrAddress = '0;
        if (w_InstrValid) begin
            o_InstrAddress = r_Addr[w_HeadIdx];
            o_InstrWord    = w_Bypass ? i_MemRespData : r_Data[w_HeadIdx];
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_FetchPc   <= RESET_VECTOR;
            r_Head      <= '0;
            r_Tail      <= '0;
            r_Fill      <= '0;
            r_DataValid <= '0;
            r_Discard   <= '0;
        end else if (i_Redirect) begin
            r_FetchPc   <= w_RedirectPc;
            r_Head      <= '0;
            r_Tail      <= '0;
            r_Fill      <= '0;
            r_DataValid <= '0;
            r_Discard   <= w_DiscardSum[DISW-1:0];
        end else begin
            if (w_ReqFire) begin
                r_Tail    <= r_Tail + PTRW'(1);
                r_FetchPc <= r_FetchPc + XLEN'(4);
            end
            if (i_MemRespValid && w_Discarding) begin
                r_Discard <= r_Discard - DISW'(1);
            end
            if (w_RespKeep) begin
                r_Fill <= r_Fill + PTRW'(1);
            end
            if (w_Pop) begin
                r_DataValid[w_HeadIdx] <= 1'b0;
                r_Head                 <= r_Head + PTRW'(1);
            end
            if (w_Write) begin
                r_DataValid[w_FillIdx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_ReqFire) begin
            r_Addr[w_TailIdx] <= r_FetchPc;
        end
        if (w_Write) begin
            r_Data[w_FillIdx] <= i_MemRespData;
        end
    end

    a_resp_has_owner: assert property (@(posedge i_Clock) disable iff (i_Reset)
        i_MemRespValid |-> (w_Discarding || (r_Tail != r_Fill)));

    a_discard_fits: assert property (@(posedge i_Clock) disable iff (i_Reset)
        i_Redirect |-> (w_DiscardSum <= (DISW+1)'(QUEUE_DEPTH)));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: directed scenarios plus randomized traffic checked every cycle
// against an epoch-tagged queue model of memory and the expected in-order instruction stream.
module tb_instruction_fetch_queue;
    localparam int unsigned D  = 4;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        o_MemReqValid;
    logic        i_MemReqReady = 1'b0;
    logic [31:0] o_MemReqAddress;
    logic        i_MemRespValid = 1'b0;
    logic [31:0] i_MemRespData = '0;
    logic        i_Redirect = 1'b0;
    logic [31:0] i_RedirectTarget = '0;
    logic        o_InstrValid;
    logic        i_InstrReady = 1'b0;
    logic [31:0] o_InstrWord;
    logic [31:0] o_InstrAddress;

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .XLEN(32),
        .QUEUE_DEPTH(D),
        .RESET_VECTOR(RV)
    ) dut (
        .i_Clock(clk),
        .i_Reset(i_Reset),
        .o_MemReqValid(o_MemReqValid),
        .i_MemReqReady(i_MemReqReady),
        .o_MemReqAddress(o_MemReqAddress),
        .i_MemRespValid(i_MemRespValid),
        .i_MemRespData(i_MemRespData),
        .i_Redirect(i_Redirect),
        .i_RedirectTarget(i_RedirectTarget),
        .o_InstrValid(o_InstrValid),
        .i_InstrReady(i_InstrReady),
        .o_InstrWord(o_InstrWord),
        .o_InstrAddress(o_InstrAddress)
    );

    typedef struct { logic [31:0] addr; int epoch; } req_t;
    typedef struct { logic [31:0] addr; logic [31:0] word; } ins_t;

    req_t        pending[$];
    ins_t        delivered[$];
    logic [31:0] m_pc = RV;
    int          m_reserved = 0;
    int          m_epoch = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        logic exp_req, exp_iv, bypass;
        ins_t hd;
        req_t e;
        if (i_Reset) begin
            chk("req_valid_in_reset", {31'b0, o_MemReqValid}, 32'd0);
            pending.delete();
            delivered.delete();
            m_pc = RV;
            m_reserved = 0;
            m_epoch++;
        end else begin
            exp_req = !i_Redirect && (m_reserved < D);
            chk("req_valid", {31'b0, o_MemReqValid}, {31'b0, exp_req});
            chk("req_addr", o_MemReqAddress, m_pc);
            bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
            bypass = i_MemRespValid && (pending.size() > 0) && (pending[0].epoch == m_epoch)
                     && (delivered.size() == 0);
`endif
            exp_iv = (delivered.size() > 0) || bypass;
            chk("instr_valid", {31'b0, o_InstrValid}, {31'b0, exp_iv});
            if (exp_iv) begin
                if (delivered.size() > 0) hd = delivered[0];
                else begin
                    hd.addr = pending[0].addr;
                    hd.word = memword(pending[0].addr);
                end
                chk("instr_addr", o_InstrAddress, hd.addr);
                chk("instr_word", o_InstrWord, hd.word);
            end
            if (i_MemRespValid && pending.size() > 0) begin
                e = pending.pop_front();
                if (e.epoch == m_epoch) delivered.push_back('{e.addr, memword(e.addr)});
            end
            if (exp_req && i_MemReqReady) begin
                pending.push_back('{m_pc, m_epoch});
                m_pc += 32'd4;
                m_reserved++;
            end
            if (exp_iv && i_InstrReady) begin
                void'(delivered.pop_front());
                m_reserved--;
            end
            if (i_Redirect) begin
                m_pc = {i_RedirectTarget[31:2], 2'b00};
                delivered.delete();
                m_reserved = 0;
                m_epoch++;
            end
        end
    end

    // Drives one cycle of inputs just after the edge; memory answers the oldest pending request.
    task automatic step(input bit rst, input bit mrdy, input bit resp, input bit rdy,
                        input bit redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        i_Reset          = rst;
        i_MemReqReady    = mrdy;
        i_InstrReady     = rdy;
        i_Redirect       = redir && !rst && (pending.size() <= D);
        i_RedirectTarget = tgt;
        i_MemRespValid   = resp && !rst && (pending.size() > 0);
        i_MemRespData    = i_MemRespValid ? memword(pending[0].addr) : 32'hDEAD_BEEF;
        #2;
    endtask

    initial begin
        int fires;
        logic [31:0] last_addr;
        logic [31:0] base;
        bit found;
        int p_mrdy, p_resp, p_rdy;

        // Steady stream from reset, 1-cycle memory
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        chk("t1_req_addr_c0", o_MemReqAddress, RV);
        chk("t1_req_valid_c0", {31'b0, o_MemReqValid}, 32'd1);
        chk("t1_instr_valid_c0", {31'b0, o_InstrValid}, 32'd0);
        chk("t1_reset_word", o_InstrWord, 32'd0);
        chk("t1_reset_addr", o_InstrAddress, 32'd0);
        step(0, 1, 1, 1, 0, 0);
`ifdef FETCH_BYPASS_EN
        chk("t1_bypass_c1_valid", {31'b0, o_InstrValid}, 32'd1);
        chk("t1_bypass_c1_addr", o_InstrAddress, 32'h0);
        base = 32'h4;
`else
        chk("t1_instr_valid_c1", {31'b0, o_InstrValid}, 32'd0);
        base = 32'h0;
`endif
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 1, 0, 0);
            chk("t1_stream_valid", {31'b0, o_InstrValid}, 32'd1);
            chk("t1_stream_addr", o_InstrAddress, base + 32'(4 * i));
        end

        // Decode stalled: queue fills to exactly QUEUE_DEPTH requests
        step(1, 0, 0, 0, 0, 0);
        fires = 0;
        last_addr = '1;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 0, 0, 0);
            if (o_MemReqValid && i_MemReqReady) begin
                fires++;
                last_addr = o_MemReqAddress;
            end
        end
        chk("t2_fires", 32'(fires), 32'd4);
        chk("t2_last_addr", last_addr, 32'hC);
        chk("t2_full_no_req", {31'b0, o_MemReqValid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 1, 0, 0);
            chk("t2_pop_addr", o_InstrAddress, 32'(4 * i));
            if (i == 1) begin
                chk("t2_resume_valid", {31'b0, o_MemReqValid}, 32'd1);
                chk("t2_resume_addr", o_MemReqAddress, 32'h10);
            end
        end

        // Memory back-pressure holds the request address
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 0, 0);
            chk("t3_hold_addr", o_MemReqAddress, 32'h8);
            chk("t3_hold_valid", {31'b0, o_MemReqValid}, 32'd1);
        end
        step(0, 1, 1, 1, 0, 0);
        chk("t3_accept_addr", o_MemReqAddress, 32'h8);
        step(0, 1, 1, 1, 0, 0);
        chk("t3_next_addr", o_MemReqAddress, 32'hC);

        // Redirect with three outstanding requests; stale responses dropped
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1, 32'h20);
        chk("t4_no_req_on_redirect", {31'b0, o_MemReqValid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, 0, 0);
            chk("t4_req_addr", o_MemReqAddress, 32'h20 + 32'(4 * i));
        end
        step(0, 1, 0, 1, 1, 32'h1003);
        chk("t4_no_req_on_redirect2", {31'b0, o_MemReqValid}, 32'd0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(0, 1, 1, 1, 0, 0);
            if (o_InstrValid) begin
                found = 1;
                chk("t4_first_addr", o_InstrAddress, 32'h1000);
                chk("t4_first_word", o_InstrWord, memword(32'h1000));
            end
        end
        chk("t4_instr_seen", {31'b0, found}, 32'd1);

        // Redirect in the same cycle as a pop and a response
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h40);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 32'h80);
        chk("t5_pop_valid", {31'b0, o_InstrValid}, 32'd1);
        chk("t5_pop_addr", o_InstrAddress, 32'h40);
        chk("t5_resp_same_cycle", {31'b0, i_MemRespValid}, 32'd1);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(0, 1, 1, 1, 0, 0);
            if (o_InstrValid) begin
                found = 1;
                chk("t5_first_after", o_InstrAddress, 32'h80);
            end
        end
        chk("t5_instr_seen", {31'b0, found}, 32'd1);

        // Reset with two outstanding requests
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("t6_valid", {31'b0, o_InstrValid}, 32'd0);
        chk("t6_word", o_InstrWord, 32'd0);
        chk("t6_addr", o_InstrAddress, 32'd0);
        chk("t6_req_addr", o_MemReqAddress, RV);
        step(0, 1, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
`ifdef FETCH_BYPASS_EN
        chk("t6_bypass_valid", {31'b0, o_InstrValid}, 32'd1);
        chk("t6_bypass_addr", o_InstrAddress, RV);
`else
        chk("t6_resp_cycle_valid", {31'b0, o_InstrValid}, 32'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("t6_next_valid", {31'b0, o_InstrValid}, 32'd1);
        chk("t6_next_addr", o_InstrAddress, RV);
`endif

        // Randomized traffic
        p_mrdy = 70;
        p_resp = 60;
        p_rdy  = 65;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                p_mrdy = $urandom_range(20, 100);
                p_resp = $urandom_range(20, 100);
                p_rdy  = $urandom_range(10, 100);
            end
            step(($urandom % 400) == 0,
                 ($urandom % 100) < p_mrdy,
                 ($urandom % 100) < p_resp,
                 ($urandom % 100) < p_rdy,
                 ($urandom % 20) == 0,
                 $urandom);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
